mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer in front of the single-port word RAM. It shares the RAM between the instruction-fetch path and the load/store data path. Each granted request becomes a timed read or write strobe sequence, with read data returned through a one-cycle acknowledge. It sits between the control unit's fetch/MAR logic and the RAM, and it owns the RAM's `read`, `write`, `Address` and `data` inputs.

## Interface
- `ADDR_DEPTH`, 512: number of RAM words; valid addresses are 0..ADDR_DEPTH-1.
- `RD_LAT`, 1: cycles the strobe is held before RAM output is captured (≥1).
- `MAX_DEFER`, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request (level, held until `if_ack`).
- `if_addr` in 32: fetch word address.
- `if_ack` out 1: one-cycle fetch completion pulse.
- `if_rdata` out 32: fetched word, valid while `if_ack`=1 and held until the next fetch ack.
- `d_req` in 1: data request (level, held until `d_ack`).
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data word address.
- `d_wdata` in 32: store data.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_rdata` out 32: load result; unchanged by stores.
- `addr_err` out 1: pulses with the ack of an out-of-range access.
- `mem_read` out 1: RAM read strobe.
- `mem_write` out 1: RAM write strobe.
- `mem_addr` out 32: RAM address.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM output.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE → BUSY on any request. The winner's port, address, `we` and wdata are latched at that edge. Out-of-range requests (addr ≥ ADDR_DEPTH) go IDLE → ACK directly, with no strobe.
- BUSY: `mem_addr`/`mem_wdata` are driven from the latched values. `mem_read`=!we or `mem_write`=we is asserted for RD_LAT cycles, counted down by the latency counter. On the last BUSY cycle the edge captures `mem_rdata` into the winner's rdata register (loads/fetches only). Then → ACK.
- ACK: pulse the winner's ack for one cycle. Assert `addr_err` if flagged; an erroring load/fetch returns rdata = 0. Then → IDLE.
- Arbitration in IDLE: data wins over fetch, unless defer_cnt = MAX_DEFER, in which case fetch wins.
- defer_cnt: increments on each data grant made while `if_req`=1, saturating at MAX_DEFER. It clears on any fetch grant.
- Only one access is in flight at a time. Requests arriving during BUSY/ACK wait and are evaluated in the next IDLE.
- A requester must drop its req in the cycle after its ack. A req still high in IDLE is a new request.
- Changing addr/data/we while req is high but not yet granted is legal; values are sampled at grant.

## Timing
- Reset values: state=IDLE, all strobes 0, `mem_addr`/`mem_wdata`=0, both acks 0, `addr_err` 0, `if_rdata`/`d_rdata`=0, defer_cnt=0.
- Latency from req visible in IDLE (cycle 0) to ack is cycle RD_LAT+1. With RD_LAT=1, ack is in cycle 2.
- Back-to-back throughput is one access per RD_LAT+2 cycles.
- Out-of-range access: ack in cycle 1, with no strobe at any point.
- Strobes are registered outputs and are never asserted in IDLE or ACK.
- Simultaneous `if_req`/`d_req` in IDLE: exactly one grant, per the arbitration rule.
- Reset mid-operation (BUSY or ACK): the next edge forces IDLE and drops the strobes. No ack is issued and the in-flight access is lost, so requesters re-request. A write whose strobe was already seen by the RAM is not undone.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/ACK);
  - the port-select encoding (PORT_IF, PORT_D);
  - the default constants ADDR_DEPTH, RD_LAT and MAX_DEFER.
- Flat module; no sub-module. The latency counter and defer counter are inline.

## Test plan
- Fetch only, `if_addr`=5, RAM[5]=0x00000005, RD_LAT=1 → `mem_read` high in cycle 1 only; `if_ack` in cycle 2 with `if_rdata`=0x00000005.
- Store then load: store `d_addr`=90, `d_wdata`=85; then load `d_addr`=90 → `mem_write` for 1 cycle, `d_ack` at cycle 2 with `d_rdata` unchanged; the following load returns 85.
- Simultaneous requests at cycle 0 → data granted first, `d_ack` at cycle 2; fetch granted in the next IDLE, `if_ack` at cycle 5.
- `d_req` held continuously with `if_req` high, MAX_DEFER=4 → exactly 4 data acks, then one fetch ack, then data resumes.
- Load with `d_addr`=600 → `d_ack` and `addr_err` in cycle 1, `d_rdata`=0, `mem_read` never asserted.
- `reset` asserted in the BUSY cycle of a fetch → next cycle IDLE, strobes 0, no `if_ack`; the re-issued fetch completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data RAM arbiter.
// One state encoding, one port-select encoding, default geometry.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam int ADDR_DEPTH = 512;
  localparam int RD_LAT     = 1;
  localparam int MAX_DEFER  = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter; slave = arbiter view.
// Requests are level-held until the matching one-cycle ack.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        addr_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, addr_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, addr_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and data paths; ack RD_LAT+1 cycles after grant (1 if out of range).
// One access in flight; other requests stall (req held) until the next IDLE, data wins unless fetch was deferred MAX_DEFER times.
module mem_arbiter #(
  parameter int ADDR_DEPTH = mem_arb_pkg::ADDR_DEPTH,
  parameter int RD_LAT     = mem_arb_pkg::RD_LAT,
  parameter int MAX_DEFER  = mem_arb_pkg::MAX_DEFER
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  port_e         r_port;
  logic          r_we;
  logic          r_err;
  logic [LW-1:0] r_lat_cnt;
  logic [DW-1:0] r_defer_cnt;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_any_req;
  logic          w_fetch_due;
  logic          w_grant_if;
  logic          w_gnt_we;
  logic          w_gnt_err;
  logic          w_lat_done;
  logic [31:0]   w_gnt_addr;
  logic [31:0]   w_gnt_wdata;
  logic          w_if_ack;
  logic          w_d_ack;
  logic          w_addr_err;

  always_comb begin
    w_any_req   = bus.if_req | bus.d_req;
    w_fetch_due = (r_defer_cnt == DW'(MAX_DEFER));
    w_grant_if  = bus.if_req & (~bus.d_req | w_fetch_due);
    w_gnt_addr  = w_grant_if ? bus.if_addr : bus.d_addr;
    w_gnt_we    = ~w_grant_if & bus.d_we;
    w_gnt_wdata = w_grant_if ? 32'd0 : bus.d_wdata;
    w_gnt_err   = (w_gnt_addr >= 32'(ADDR_DEPTH));
    w_lat_done  = (r_lat_cnt == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_if_ack    = 1'b0;
    w_d_ack     = 1'b0;
    w_addr_err  = 1'b0;
    case (r_state)
      IDLE: begin
        // Out-of-range accesses skip BUSY so the RAM never sees a strobe
        if (w_any_req) w_state_nxt = w_gnt_err ? ACK : BUSY;
      end
      BUSY: begin
        if (w_lat_done) w_state_nxt = ACK;
      end
      ACK: begin
        w_if_ack    = (r_port == PORT_IF);
        w_d_ack     = (r_port == PORT_D);
        w_addr_err  = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_port      <= PORT_IF;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_lat_cnt   <= '0;
      r_defer_cnt <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_port      <= w_grant_if ? PORT_IF : PORT_D;
            r_we        <= w_gnt_we;
            r_err       <= w_gnt_err;
            r_mem_addr  <= w_gnt_addr;
            r_mem_wdata <= w_gnt_wdata;
            r_lat_cnt   <= LW'(RD_LAT - 1);
            r_mem_read  <= ~w_gnt_err & ~w_gnt_we;
            r_mem_write <= ~w_gnt_err & w_gnt_we;
            // Only data grants that actually bypass a waiting fetch count toward starvation
            if (w_grant_if)
              r_defer_cnt <= '0;
            else if (bus.if_req && !w_fetch_due)
              r_defer_cnt <= r_defer_cnt + DW'(1);
            if (w_gnt_err && !w_gnt_we) begin
              if (w_grant_if) r_if_rdata <= 32'd0;
              else            r_d_rdata  <= 32'd0;
            end
          end
        end
        BUSY: begin
          if (w_lat_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_port == PORT_IF) r_if_rdata <= bus.mem_rdata;
            else if (!r_we)        r_d_rdata  <= bus.mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_ack    = w_if_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.addr_err  = w_addr_err;

endmodule
